// File: rtl/keypad_matrix_scanner_if.sv
// Key report handshake between the keypad scanner and its consumer.
// Signals:
//   keyValid - producer: keyCode holds an unconsumed press
//   keyCode  - producer: key index = column*4 + row
//   keyReady - consumer: accepts keyCode on an edge where keyValid && keyReady
// Modports: master = scanner (producer), slave = consumer.
interface keypad_matrix_scanner_if;
    logic       keyValid;
    logic [3:0] keyCode;
    logic       keyReady;

    modport master (
        output keyValid,
        output keyCode,
        input  keyReady
    );

    modport slave (
        input  keyValid,
        input  keyCode,
        output keyReady
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner with debounce and valid/ready key reporting.
// One column is strobed low at a time. Rows are synchronised, then sampled at the end of each
// column slot. Each complete 4-column scan yields the lowest pressed key index or "none". A
// debounce FSM needs DEBOUNCE_SCANS identical scans to accept a press or a release.
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   rowPinInput       - matrix rows, active-low, asynchronous to clock
//   columnPinOutput   - matrix columns, active-low, exactly one low at a time
//   key_if (master)   - keyValid/keyCode/keyReady report handshake
//   keyPressed        - debounced "a key is held" level
//   keyOverrun        - one-cycle pulse when a press is dropped because keyValid was still set
//   segmentPinsOutput - 7-segment pattern for keyCode (only with KEYPAD_SEG_OUT_EN defined)
// Optional feature macro: KEYPAD_SEG_OUT_EN.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_TICKS     = 24000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               rowPinInput,
    output logic [3:0]               columnPinOutput,
    keypad_matrix_scanner_if.master  key_if,
    output logic                     keyPressed,
`ifdef KEYPAD_SEG_OUT_EN
    output logic                     keyOverrun,
    output logic [7:0]               segmentPinsOutput
`else
    output logic                     keyOverrun
`endif
);

    localparam int unsigned PrescW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_TICKS - 1);
    localparam logic [CntW-1:0]   CntTarget = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StHeld,
        StDebRel
    } state_e;

    // Row synchroniser
    logic [3:0] row_meta_q, row_sync_q;

    // Scan timing
    logic [PrescW-1:0] presc_q, presc_d;
    logic [1:0]        col_q, col_d;
    logic              tick;

    // Per-scan accumulation and the registered result of the last complete scan
    logic       scan_found_q, scan_found_d;
    logic [3:0] scan_key_q, scan_key_d;
    logic       scan_done_q, scan_done_d;
    logic       res_found_q, res_found_d;
    logic [3:0] res_key_q, res_key_d;

    // Debounce FSM; cand_q also holds the accepted key while in StHeld/StDebRel
    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            go_idle;

    // Outputs
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;
    logic       pressed_q, pressed_d;
    logic       overrun_q, overrun_d;

    logic       col_hit;
    logic [1:0] col_row;

    assign tick            = (presc_q == PrescLast);
    assign columnPinOutput = ~(4'b0001 << col_q);

    // Lowest low row in the column currently strobed
    always_comb begin
        col_hit = 1'b0;
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                col_hit = 1'b1;
                col_row = 2'(r);
            end
        end
    end

    // Prescaler, column advance and scan accumulation
    always_comb begin
        presc_d      = presc_q + PrescW'(1);
        col_d        = col_q;
        scan_found_d = scan_found_q;
        scan_key_d   = scan_key_q;
        scan_done_d  = 1'b0;
        res_found_d  = res_found_q;
        res_key_d    = res_key_q;
        if (tick) begin
            presc_d = '0;
            col_d   = col_q + 2'd1;
            // Columns are visited in ascending order, so the first hit is the lowest index.
            if (col_q == 2'd0) begin
                scan_found_d = col_hit;
                scan_key_d   = {col_q, col_row};
            end else if (!scan_found_q && col_hit) begin
                scan_found_d = 1'b1;
                scan_key_d   = {col_q, col_row};
            end
            if (col_q == 2'd3) begin
                scan_done_d = 1'b1;
                res_found_d = scan_found_d;
                res_key_d   = scan_key_d;
            end
        end
    end

    // Debounce FSM, stepped once per completed scan
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (scan_done_q) begin
            unique case (state_q)
                StIdle: begin
                    if (res_found_q) begin
                        cand_d = res_key_q;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                        end else begin
                            state_d = StDebPress;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StDebPress: begin
                    if (!res_found_q) begin
                        state_d = StIdle;
                    end else if (res_key_q == cand_q) begin
                        if (cnt_q == CntLast) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                            cnt_d   = CntTarget;
                        end else if (cnt_q != CntTarget) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        cand_d = res_key_q;
                        cnt_d  = CntW'(1);
                    end
                end
                StHeld: begin
                    if (!res_found_q) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StDebRel;
                            cnt_d   = CntW'(1);
                        end
                    end else if (res_key_q != cand_q) begin
                        cand_d = res_key_q;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StDebPress;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StDebRel: begin
                    if (!res_found_q) begin
                        if (cnt_q == CntLast) begin
                            state_d = StIdle;
                            cnt_d   = CntTarget;
                        end else if (cnt_q != CntTarget) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else if (res_key_q == cand_q) begin
                        state_d = StHeld;
                    end else begin
                        state_d = StDebPress;
                        cand_d  = res_key_q;
                        cnt_d   = CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign go_idle = (state_d == StIdle) && (state_q != StIdle);

    // Report handshake: a consume on the accepting edge frees the slot for the new code.
    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        pressed_d = pressed_q;
        overrun_d = 1'b0;
        if (valid_q && key_if.keyReady) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            pressed_d = 1'b1;
            if (!valid_q || key_if.keyReady) begin
                valid_d = 1'b1;
                code_d  = cand_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (go_idle) begin
            pressed_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta_q   <= 4'b1111;
            row_sync_q   <= 4'b1111;
            presc_q      <= '0;
            col_q        <= 2'd0;
            scan_found_q <= 1'b0;
            scan_key_q   <= 4'd0;
            scan_done_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_key_q    <= 4'd0;
            state_q      <= StIdle;
            cand_q       <= 4'd0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            code_q       <= 4'd0;
            pressed_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            row_meta_q   <= rowPinInput;
            row_sync_q   <= row_meta_q;
            presc_q      <= presc_d;
            col_q        <= col_d;
            scan_found_q <= scan_found_d;
            scan_key_q   <= scan_key_d;
            scan_done_q  <= scan_done_d;
            res_found_q  <= res_found_d;
            res_key_q    <= res_key_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            pressed_q    <= pressed_d;
            overrun_q    <= overrun_d;
        end
    end

    assign key_if.keyValid = valid_q;
    assign key_if.keyCode  = code_q;
    assign keyPressed      = pressed_q;
    assign keyOverrun      = overrun_q;

`ifdef KEYPAD_SEG_OUT_EN
    logic [7:0] seg_q, seg_d;

    always_comb begin
        unique case (code_d)
            4'd0:    seg_d = 8'h3F;
            4'd1:    seg_d = 8'h21;
            4'd2:    seg_d = 8'h5B;
            4'd3:    seg_d = 8'h73;
            4'd4:    seg_d = 8'h65;
            4'd5:    seg_d = 8'h76;
            4'd6:    seg_d = 8'h7E;
            4'd7:    seg_d = 8'h23;
            4'd8:    seg_d = 8'h7F;
            4'd9:    seg_d = 8'h77;
            default: seg_d = 8'h40;
        endcase
    end

    // Only reload with keyCode so the pattern tracks the reported code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q <= 8'h00;
        end else if (code_d != code_q || (accept && valid_d && !valid_q)) begin
            seg_q <= seg_d;
        end
    end

    assign segmentPinsOutput = seg_q;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner (SCAN_TICKS=4, DEBOUNCE_SCANS=2).
// A key-matrix model drives the rows from the strobed column; expectations come from the
// press/release rules (lowest held index, latency bound, one report per press).
module tb_keypad_matrix_scanner;
    localparam int T    = 4;
    localparam int D    = 2;
    localparam int SCAN = 4 * T;
    localparam int LAT  = (D + 1) * SCAN + 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  rowPinInput;
    logic [3:0]  columnPinOutput;
    logic        keyPressed;
    logic        keyOverrun;
`ifdef KEYPAD_SEG_OUT_EN
    logic [7:0]  segmentPinsOutput;
    logic [7:0]  seg_tab [16] = '{8'h3F, 8'h21, 8'h5B, 8'h73, 8'h65, 8'h76, 8'h7E, 8'h23,
                                  8'h7F, 8'h77, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
`endif
    logic [15:0] keys_down;

    int checks = 0;
    int fails  = 0;

    keypad_matrix_scanner_if key_bus ();

    keypad_matrix_scanner #(
        .SCAN_TICKS    (T),
        .DEBOUNCE_SCANS(D)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rowPinInput      (rowPinInput),
        .columnPinOutput  (columnPinOutput),
        .key_if           (key_bus.master),
        .keyPressed       (keyPressed),
`ifdef KEYPAD_SEG_OUT_EN
        .keyOverrun       (keyOverrun),
        .segmentPinsOutput(segmentPinsOutput)
`else
        .keyOverrun       (keyOverrun)
`endif
    );

    always #5 clock = ~clock;

    // Passive matrix: a held key pulls its row low while its column is strobed low.
    always_comb begin
        rowPinInput = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (columnPinOutput[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys_down[c * 4 + r]) rowPinInput[r] = 1'b0;
                end
            end
        end
    end

    function automatic int lowest_key(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < LAT; n++) begin
            @(negedge clock);
            if (key_bus.keyValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_latency"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_release(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < LAT + SCAN; n++) begin
            @(negedge clock);
            if (keyPressed === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_release"}, 32'(ok), 32'd1);
    endtask

    task automatic consume(input string tag);
        @(negedge clock);
        key_bus.keyReady = 1'b1;
        @(negedge clock);
        key_bus.keyReady = 1'b0;
        check({tag, "_consumed"}, 32'(key_bus.keyValid), 32'd0);
    endtask

    // keyValid must stay low for n cycles.
    task automatic expect_quiet(input string tag, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (key_bus.keyValid !== 1'b0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic press_report(input string tag, input logic [15:0] m);
        keys_down = m;
        wait_valid(tag);
        check({tag, "_code"}, 32'(key_bus.keyCode), 32'(lowest_key(m)));
        check({tag, "_pressed"}, 32'(keyPressed), 32'd1);
`ifdef KEYPAD_SEG_OUT_EN
        check({tag, "_seg"}, 32'(segmentPinsOutput), 32'(seg_tab[lowest_key(m)]));
`endif
    endtask

    initial begin
        int ovr_cycles;
        logic [15:0] m;
        bit bad;

        reset            = 1'b1;
        keys_down        = 16'h0000;
        key_bus.keyReady = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_col", 32'(columnPinOutput), 32'hE);
        check("rst_valid", 32'(key_bus.keyValid), 32'd0);
        check("rst_code", 32'(key_bus.keyCode), 32'd0);
        check("rst_pressed", 32'(keyPressed), 32'd0);
        check("rst_overrun", 32'(keyOverrun), 32'd0);
`ifdef KEYPAD_SEG_OUT_EN
        check("rst_seg", 32'(segmentPinsOutput), 32'd0);
`endif
        reset = 1'b0;

        // Asynchronous reset in the middle of column 1
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("async_rst_col", 32'(columnPinOutput), 32'hE);
        check("async_rst_valid", 32'(key_bus.keyValid), 32'd0);
        check("async_rst_pressed", 32'(keyPressed), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Column k/T after k edges since release
        bad = 1'b0;
        for (int k = 0; k < 2 * SCAN; k++) begin
            if (k > 0) @(negedge clock);
            if (columnPinOutput !== ~(4'b0001 << ((k / T) % 4))) bad = 1'b1;
        end
        check("col_sequence", 32'(bad), 32'd0);

        // Clean press of column 2 row 1
        press_report("clean", 16'h0200);
        bad = 1'b0;
        ovr_cycles = 0;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clock);
            if (key_bus.keyValid !== 1'b1 || key_bus.keyCode !== 4'd9) bad = 1'b1;
            if (keyOverrun === 1'b1) ovr_cycles++;
        end
        check("clean_stable", 32'(bad), 32'd0);
        check("clean_no_overrun", 32'(ovr_cycles), 32'd0);
        consume("clean");
        expect_quiet("clean_single_report", 4 * SCAN);
        keys_down = 16'h0000;
        wait_release("clean");

        // Bounce at scan rate: successive scans alternate seen/not seen, never D in a row
        for (int i = 0; i < 8; i++) begin
            keys_down = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (SCAN) begin
                @(negedge clock);
                if (key_bus.keyValid !== 1'b0) bad = 1'b1;
            end
        end
        check("bounce_no_report", 32'(bad), 32'd0);
        press_report("bounce_settle", 16'h0200);
        consume("bounce_settle");
        expect_quiet("bounce_single_report", 4 * SCAN);
        keys_down = 16'h0000;
        wait_release("bounce_settle");

        // Overrun: second press while the first report is still pending
        press_report("ovr_first", 16'h0008);
        keys_down = 16'h0000;
        wait_release("ovr_first");
        keys_down  = 16'h0020;
        ovr_cycles = 0;
        for (int i = 0; i < LAT + SCAN; i++) begin
            @(negedge clock);
            if (keyOverrun === 1'b1) ovr_cycles++;
        end
        check("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
        check("ovr_code_kept", 32'(key_bus.keyCode), 32'd3);
        check("ovr_valid_kept", 32'(key_bus.keyValid), 32'd1);
        check("ovr_pressed", 32'(keyPressed), 32'd1);
        consume("ovr");
        keys_down = 16'h0000;
        wait_release("ovr_second");

        // Multi-key: lowest index wins, then the survivor reports on release of the other
        press_report("multi_both", 16'h2040);
        consume("multi_both");
        press_report("multi_remaining", 16'h2000);
        consume("multi_remaining");
        keys_down = 16'h0000;
        wait_release("multi");

`ifdef KEYPAD_SEG_OUT_EN
        press_report("seg_key7", 16'h0080);
        check("seg_7_pattern", 32'(segmentPinsOutput), 32'h23);
        consume("seg_key7");
        keys_down = 16'h0000;
        wait_release("seg_key7");
        press_report("seg_key12", 16'h1000);
        check("seg_12_pattern", 32'(segmentPinsOutput), 32'h40);
        consume("seg_key12");
        keys_down = 16'h0000;
        wait_release("seg_key12");
`endif

        // Reset while a report is pending discards it
        press_report("hs_rst", 16'h0004);
        #2 reset = 1'b1;
        #1 check("hs_rst_valid", 32'(key_bus.keyValid), 32'd0);
        keys_down = 16'h0000;
        @(negedge clock);
        reset = 1'b0;
        expect_quiet("hs_rst_no_report", 4 * SCAN);
        check("hs_rst_pressed", 32'(keyPressed), 32'd0);

        // Random one- or two-key presses
        for (int i = 0; i < 8; i++) begin
            m = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) m = m | (16'h0001 << $urandom_range(0, 15));
            press_report($sformatf("rand%0d", i), m);
            consume($sformatf("rand%0d", i));
            keys_down = 16'h0000;
            wait_release($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
